// File: rtl/soc.sv
// soc: free-running tick counter shown as 8 hex digits on a multiplexed active-low seven-segment display
module soc #(
  parameter int SCAN_BITS = 2,
  parameter int TICK_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] an = 8'hFF,
  output logic [6:0] a_to_g = 7'h7F
);
  localparam logic [6:0] seg_lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [TICK_BITS-1:0] tick_pre = '0;
  logic [31:0]          tick_cnt = '0;
  logic [SCAN_BITS-1:0] scan_pre = '0;
  logic [2:0]           idx = '0;
  logic [31:0]          disp = '0;
  logic                 scan_step;
  logic                 wrap;
  assign scan_step = &scan_pre;
  assign wrap = scan_step && idx == 3'd7;
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_pre <= '0;
      tick_cnt <= '0;
      scan_pre <= '0;
      idx <= '0;
      disp <= '0;
      an <= 8'hFF;
      a_to_g <= 7'h7F;
    end else begin
      tick_pre <= tick_pre + 1'b1;
      tick_cnt <= tick_cnt + 32'(&tick_pre);
      scan_pre <= scan_pre + 1'b1;
      idx <= idx + 3'(scan_step);
      disp <= wrap ? tick_cnt : disp;
      an <= ~(8'b1 << idx);
      a_to_g <= seg_lut[disp[4*idx +: 4]];
    end
  end
endmodule

// File: tb/tb_soc.sv
// tb_soc: scoreboard bench for the soc seven-segment scanner
module tb_soc;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] an;
  logic [6:0] a_to_g;
  int checks = 0;
  int failures = 0;
  typedef struct {
    bit         chk;
    logic [7:0] an;
    logic [6:0] seg;
    string      tag;
  } exp_t;
  exp_t q[$];
  exp_t e;
  localparam logic [6:0] seg_lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  soc #(.SCAN_BITS(2), .TICK_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .a_to_g(a_to_g)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [7:0] a, input logic [6:0] s, input string tag);
    rst = r;
    q.push_back('{1'b1, a, s, tag});
    @(negedge clk);
  endtask
  task automatic scan(input int k, input logic [31:0] d, input string tag);
    logic [2:0] i;
    logic [31:0] dv;
    i = 3'(((k - 1) / 4) % 8);
    dv = d >> (4 * i);
    step(1'b0, ~(8'b1 << i), seg_lut[dv[3:0]], $sformatf("%s k=%0d", tag, k));
  endtask
  task automatic run(input int from, input int to, input logic [31:0] d, input string tag);
    for (int k = from; k <= to; k++) scan(k, d, tag);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          checks++;
          if (an !== e.an || a_to_g !== e.seg) begin
            failures++;
            $display("FAIL %s: an=%h a_to_g=%b, required an=%h a_to_g=%b", e.tag, an, a_to_g, e.an, e.seg);
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    checks++;
    if (an !== 8'hFF || a_to_g !== 7'h7F) begin
      failures++;
      $display("FAIL powerup: an=%h a_to_g=%b, required an=ff a_to_g=1111111", an, a_to_g);
    end
    run(1, 32, 32'h0, "scan");
    run(33, 40, 32'h1, "scan");
    force dut.disp = 32'h7654_3210;
    run(41, 72, 32'h7654_3210, "dec0");
    force dut.disp = 32'hFEDC_BA98;
    run(73, 104, 32'hFEDC_BA98, "dec1");
    release dut.disp;
    repeat (3) step(1'b1, 8'hFF, 7'h7F, "rst_hold");
    run(1, 32, 32'h0, "post");
    run(33, 52, 32'h1, "post");
    step(1'b1, 8'hFF, 7'h7F, "mid_rst");
    run(1, 32, 32'h0, "restart");
    run(33, 40, 32'h1, "restart");
    step(1'b1, 8'hFF, 7'h7F, "wrap_rst");
    scan(1, 32'h0, "wrap");
    force dut.tick_cnt = 32'hFFFF_FFFF;
    scan(2, 32'h0, "wrap");
    release dut.tick_cnt;
    run(3, 64, 32'h0, "wrap");
    for (int n = 0; n < 4 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
